// File: rtl/miner_pkg.sv
// Shared constants and types for the nonce-sweeping double-SHA256 controller.
package miner_pkg;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Message bit lengths written into the final padding word of each block.
  localparam logic [63:0] LEN_HDR = 64'd640;
  localparam logic [63:0] LEN_DIG = 64'd256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MID,
    S_BLK2,
    S_DBL,
    S_CHECK
  } state_e;

  function automatic logic [31:0] byteswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/nonce_stepper.sv
// Nonce register with load/step and a 33-bit compare so the sweep never wraps past the limit.
module nonce_stepper #(
  parameter logic [31:0] START  = 32'h0000_0000,
  parameter logic [31:0] STRIDE = 32'd1,
  parameter logic [31:0] LIMIT  = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] nonce_o,
  output logic [31:0] next_o,
  output logic        last_o
);

  logic [31:0] nonce_q;
  logic [32:0] sum;

  assign sum     = {1'b0, nonce_q} + {1'b0, STRIDE};
  assign next_o  = sum[31:0];
  assign last_o  = sum > {1'b0, LIMIT};
  assign nonce_o = nonce_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       nonce_q <= '0;
    else if (load_i) nonce_q <= START;
    else if (step_i) nonce_q <= sum[31:0];
  end

endmodule

// File: rtl/miner_sequencer.sv
// Sweeps nonces through an external SHA256 compression core: midstate once, then
// second block + double hash per nonce, checking trailing zero bits of the raw digest.
module miner_sequencer
  import miner_pkg::*;
#(
  parameter logic [31:0] NONCE_START  = 32'h0000_0000,
  parameter logic [31:0] NONCE_STRIDE = 32'd1,
  parameter logic [31:0] NONCE_LIMIT  = 32'hFFFF_FFFF,
  parameter int unsigned ZERO_BITS    = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [255:0] hash_out,
  output logic [31:0]  nonce_out,
  output logic         sha_start,
  output logic [511:0] sha_block,
  output logic [255:0] sha_h_in,
  input  logic         sha_done,
  input  logic [255:0] sha_h_out
);

  localparam logic [255:0] ZMASK = {256{1'b1}} >> (256 - ZERO_BITS);

  state_e       state_q;
  logic [95:0]  tail_q;
  logic [255:0] mid_q;
  logic [255:0] dig2_q;
  logic [31:0]  nonce, nonce_nxt;
  logic         last, hit, kill, load, step;
  logic         unused_nonce_field;

  // The header's own nonce field is replaced by the swept counter.
  assign unused_nonce_field = ^header[31:0];

  function automatic logic [511:0] blk2(input logic [95:0] tail, input logic [31:0] n);
    return {tail, byteswap32(n), 1'b1, 319'b0, LEN_HDR};
  endfunction

  assign hit  = (dig2_q & ZMASK) == '0;
  assign kill = abort && (state_q != S_IDLE);
  assign load = (state_q == S_IDLE) && start;
  assign step = (state_q == S_CHECK) && !kill && !hit && !last;

  nonce_stepper #(
    .START (NONCE_START),
    .STRIDE(NONCE_STRIDE),
    .LIMIT (NONCE_LIMIT)
  ) u_stepper (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (load),
    .step_i (step),
    .nonce_o(nonce),
    .next_o (nonce_nxt),
    .last_o (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tail_q    <= '0;
      mid_q     <= '0;
      dig2_q    <= '0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      hash_out  <= '0;
      nonce_out <= '0;
      sha_start <= 1'b0;
      sha_block <= '0;
      sha_h_in  <= '0;
    end else begin
      sha_start <= 1'b0;
      if (kill) begin
        // Any outstanding sha_done is dropped because IDLE never looks at it.
        state_q <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            tail_q    <= header[127:32];
            found     <= 1'b0;
            exhausted <= 1'b0;
            hash_out  <= '0;
            nonce_out <= '0;
            busy      <= 1'b1;
            sha_start <= 1'b1;
            sha_block <= header[639:128];
            sha_h_in  <= SHA_IV;
            state_q   <= S_MID;
          end
          S_MID: if (sha_done) begin
            mid_q     <= sha_h_out;
            sha_start <= 1'b1;
            sha_block <= blk2(tail_q, nonce);
            sha_h_in  <= sha_h_out;
            state_q   <= S_BLK2;
          end
          S_BLK2: if (sha_done) begin
            sha_start <= 1'b1;
            sha_block <= {sha_h_out, 1'b1, 191'b0, LEN_DIG};
            sha_h_in  <= SHA_IV;
            state_q   <= S_DBL;
          end
          S_DBL: if (sha_done) begin
            dig2_q  <= sha_h_out;
            state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (hit) begin
              found     <= 1'b1;
              hash_out  <= dig2_q;
              nonce_out <= nonce;
              busy      <= 1'b0;
              state_q   <= S_IDLE;
            end else if (last) begin
              exhausted <= 1'b1;
              busy      <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              sha_start <= 1'b1;
              sha_block <= blk2(tail_q, nonce_nxt);
              sha_h_in  <= mid_q;
              state_q   <= S_BLK2;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/miner_sequencer.md
# miner_sequencer

Nonce-sweeping controller for Bitcoin double-SHA256 mining; next generation of the single-shot miner control path. It computes the header midstate once, then for each nonce issues second-block and double-hash jobs to an external SHA256 compression core through a start/done handshake, and compares each final digest against a parametrised difficulty. Start nonce, stride and limit are parameters, so N instances can split the 32-bit nonce space across N cores.

## Interface
Parameters:
- NONCE_START, 32'h0000_0000, first nonce tried after `start`
- NONCE_STRIDE, 32'd1, nonce increment (N for N-way partition)
- NONCE_LIMIT, 32'hFFFF_FFFF, last nonce allowed (inclusive)
- ZERO_BITS, 32, required trailing zero bits of raw digest, 1..255

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; latches `header` and begins a sweep
- abort  in  1  pulse; ends sweep, returns to IDLE
- header  in  640  raw 80-byte header, byte 0 in [639:632]; nonce field [31:0] ignored
- busy  out  1  sweep in progress
- found  out  1  sticky success flag
- exhausted  out  1  sticky flag: limit passed without success
- hash_out  out  256  winning digest, h0 in [255:224]; zero unless `found`
- nonce_out  out  32  winning nonce (counter value); zero unless `found`
- sha_start  out  1  one-cycle job request to core
- sha_block  out  512  message block for job
- sha_h_in  out  256  chaining input for job
- sha_done  in  1  one-cycle pulse; `sha_h_out` valid this cycle
- sha_h_out  in  256  compression result (IV/chaining added)

## Operation
- States: IDLE, MID, BLK2, DBL, CHECK.
- IDLE: `start` latches header, loads nonce=NONCE_START, clears found/exhausted/hash_out/nonce_out, enters MID.
- MID: job block = header[639:128], h_in = SHA256 IV; on done store midstate, enter BLK2. Runs once per `start`.
- BLK2: block = {header[127:32], byteswap(nonce), 1'b1, 319'b0, 64'd640}, h_in = midstate; on done register digest1, enter DBL.
- DBL: block = {digest1, 1'b1, 191'b0, 64'd256}, h_in = IV; on done register digest2, enter CHECK.
- CHECK: if digest2[ZERO_BITS-1:0]==0 -> found=1, hash_out=digest2, nonce_out=nonce, IDLE. Else if nonce+STRIDE (33-bit sum) > NONCE_LIMIT -> exhausted=1, IDLE. Else nonce+=STRIDE, BLK2.
- `start` while busy ignored. `abort` in any busy state -> IDLE next cycle, flags unchanged, in-flight `sha_done` discarded.
- `sha_done` outside a waiting state ignored.

## Timing
- All outputs register; reset value 0 for every output; state IDLE.
- `sha_start` asserted exactly one cycle on state entry (MID/BLK2/DBL); sha_block/sha_h_in stable from sha_start until sha_done cycle inclusive.
- Core latency L (start to done) is arbitrary >= 1; controller adds one cycle per job.
- start -> first MID sha_start: 1 cycle. Per-nonce period: 2L+3 cycles.
- found/exhausted rise the cycle after CHECK, same cycle busy falls.
- Reset mid-job: next cycle IDLE, all outputs 0; late `sha_done` ignored.
- `start` and `abort` same cycle in IDLE: start wins; in busy: abort wins.

## Structure
- Package `miner_pkg`: SHA256 IV (8×32), length constants 640/256, state enum, byteswap32 function.
- Sub-module `nonce_stepper`: holds nonce, load/step inputs, 33-bit limit compare, `last` output.
- SHA256 core instantiated outside; this block owns only the handshake.

## Test plan
- Genesis header, NONCE_START=0x7C2BAC1D, ZERO_BITS=32 -> found after 1 nonce, nonce_out=0x7C2BAC1D, hash_out=0x6fe28c0a…68d6190000000000, 3 sha_start pulses.
- Same header, NONCE_START=0x7C2BAC1B -> found, nonce_out=0x7C2BAC1D, 7 sha_start pulses (midstate reused once).
- Genesis, START=0, LIMIT=3, ZERO_BITS=64 -> exhausted=1 after 4 nonces, hash_out=0, 9 sha_start pulses.
- START=0xFFFF_FFF9, STRIDE=4 -> nonces 0xFFFF_FFF9, 0xFFFF_FFFD tried, then exhausted (no wrap to 0x1).
- Model core with random L in 1..70; reset asserted while waiting in DBL -> next cycle all outputs 0, late sha_done produces no sha_start.
- `start` pulsed during BLK2 ignored; `abort` in DBL -> busy=0 next cycle, found=exhausted=0.
